// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root sequencer: state encoding, ALU opcodes, ALU control codes.
// Latency: none (package only).
// Backpressure: not applicable.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_t;

    // ALU opcode field
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_EQ      = 3'b010;
    localparam logic [2:0] OP_SHL     = 3'b011;
    localparam logic [2:0] OP_PASS_DR = 3'b100;
    localparam logic [2:0] OP_PASS_AC = 3'b101;
    localparam logic [2:0] OP_NOT     = 3'b110;
    localparam logic [2:0] OP_EXT     = 3'b111;

    // ALU control field, only meaningful with OP_EXT
    localparam logic [1:0] CTL_NONE = 2'b00;
    localparam logic [1:0] CTL_LOAD = 2'b01;
    localparam logic [1:0] CTL_SUB  = 2'b10;

endpackage

// File: rtl/sqrt_sequencer.sv
// Integer square root of an 8-bit radicand by successive odd-number subtraction through the external ALU.
// Latency: done rises root+2 clocks after the edge that samples start (LOAD, then root+1 SUB cycles).
// Backpressure: none; start is only sampled in IDLE, a start while busy or in DONE is dropped (no queueing).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start / operand            request and 8-bit radicand (operand must be stable during LOAD)
//   busy / done / root         LOAD..last SUB indicator, one-cycle completion pulse, floor(sqrt(N))
//   alu_control/opcode/ac/dr   drive the ALU; Moore-decoded from state and internal registers
//   alu_result / alu_carry     ALU result and borrow, consumed on the next edge
//   remainder                  N - root^2, present only when SQRT_REMAINDER_EN is defined
module sqrt_sequencer
    import sqrt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] operand,
    output logic       busy,
    output logic       done,
    output logic [7:0] root,
`ifdef SQRT_REMAINDER_EN
    output logic [7:0] remainder,
`endif
    output logic [1:0] alu_control,
    output logic [2:0] alu_opcode,
    output logic [7:0] alu_ac,
    output logic [7:0] alu_dr,
    input  logic [7:0] alu_result,
    input  logic       alu_carry
);

    state_t     state;
    logic [7:0] rem;
    logic [7:0] odd;
    logic [7:0] cnt;

    // ALU drive depends only on state and registers, except that LOAD
    // passes the operand straight through so it only has to be stable
    // during the LOAD cycle itself.
    always_comb begin
        alu_opcode  = OP_PASS_AC;
        alu_control = CTL_NONE;
        alu_ac      = 8'd0;
        alu_dr      = 8'd0;
        case (state)
            LOAD: begin
                alu_opcode  = OP_EXT;
                alu_control = CTL_LOAD;
                alu_dr      = operand;
            end
            SUB: begin
                alu_opcode  = OP_EXT;
                alu_control = CTL_SUB;
                alu_ac      = rem;
                alu_dr      = odd;
            end
            default: ;
        endcase
    end

    // busy and done are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= 8'd0;
            odd       <= 8'd0;
            cnt       <= 8'd0;
            root      <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SQRT_REMAINDER_EN
            remainder <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    rem   <= alu_result;
                    odd   <= 8'd1;
                    cnt   <= 8'd0;
                    state <= SUB;
                end
                SUB: begin
                    if (!alu_carry) begin
                        // rem >= odd: one more odd number fits
                        rem <= alu_result;
                        cnt <= cnt + 8'd1;
                        odd <= odd + 8'd2;
                    end else begin
                        // borrow: cnt odd numbers were removed, so cnt = floor(sqrt(N))
                        root      <= cnt;
`ifdef SQRT_REMAINDER_EN
                        remainder <= rem;
`endif
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Bench for sqrt_sequencer: ALU datapath, directed vector table, exhaustive back-to-back sweep,
// ignored start while busy, mid-operation reset, and randomized operands against an arithmetic reference.
// Build with SQRT_REMAINDER_EN defined to also check the remainder output.
module tb_sqrt_sequencer;
    import sqrt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] operand;
    logic       busy;
    logic       done;
    logic [7:0] root;
`ifdef SQRT_REMAINDER_EN
    logic [7:0] remainder;
`endif
    logic [1:0] alu_control;
    logic [2:0] alu_opcode;
    logic [7:0] alu_ac;
    logic [7:0] alu_dr;
    logic [7:0] alu_result;
    logic       alu_carry;

    always #5 clk = ~clk;

    sqrt_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .operand     (operand),
        .busy        (busy),
        .done        (done),
        .root        (root),
`ifdef SQRT_REMAINDER_EN
        .remainder   (remainder),
`endif
        .alu_control (alu_control),
        .alu_opcode  (alu_opcode),
        .alu_ac      (alu_ac),
        .alu_dr      (alu_dr),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry)
    );

    // Combinational ALU datapath feeding the sequencer
    always_comb begin
        logic [8:0] diff;
        diff       = {1'b0, alu_ac} - {1'b0, alu_dr};
        alu_result = alu_ac;
        alu_carry  = 1'b0;
        case (alu_opcode)
            OP_ADD:     {alu_carry, alu_result} = {1'b0, alu_ac} + {1'b0, alu_dr};
            OP_SUB:     {alu_carry, alu_result} = diff;
            OP_EQ:      alu_result = {7'd0, alu_ac == alu_dr};
            OP_SHL:     {alu_carry, alu_result} = {alu_ac, 1'b0};
            OP_PASS_DR: alu_result = alu_dr;
            OP_PASS_AC: alu_result = alu_ac;
            OP_NOT:     alu_result = ~alu_ac;
            OP_EXT: begin
                case (alu_control)
                    CTL_LOAD: alu_result = alu_dr;
                    CTL_SUB:  {alu_carry, alu_result} = diff;
                    default:  alu_result = alu_ac;
                endcase
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;
    int dr_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_sqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Issue one request. gap = edges until busy rises, lat = edges from the
    // accepting edge to the edge after which done is high. Returns at the
    // falling edge inside the done cycle. poke re-pulses start with a
    // different operand while busy.
    task automatic run_op(input logic [7:0] n, input bit poke,
                          output int r, output int rem_o, output int lat,
                          output int gap, output bit ok);
        ok = 1'b1;
        r = 0;
        rem_o = 0;
        lat = 0;
        gap = 0;
        dr_q.delete();
        operand = n;
        start = 1'b1;
        do begin
            @(posedge clk);
            #1;
            gap++;
        end while (!busy && gap < 10);
        start = 1'b0;
        if (!busy) begin
            ok = 1'b0;
            return;
        end
        forever begin
            @(negedge clk);
            if (done) break;
            if (!busy) begin
                ok = 1'b0;
                break;
            end
            if (alu_control == CTL_SUB) dr_q.push_back(int'(alu_dr));
            if (poke && lat == 3) begin
                start = 1'b1;
                operand = ~n;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            if (lat > 40) begin
                ok = 1'b0;
                break;
            end
        end
        start = 1'b0;
        r = int'(root);
`ifdef SQRT_REMAINDER_EN
        rem_o = int'(remainder);
`endif
    endtask

    typedef struct {
        logic [7:0] n;
        int         exp_root;
        int         exp_lat;
        int         exp_rem;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int r, rem_o, lat, gap, pulses;
        bit ok;

        vecs[0] = '{8'd0,   0,  2,  0};
        vecs[1] = '{8'd16,  4,  6,  0};
        vecs[2] = '{8'd17,  4,  6,  1};
        vecs[3] = '{8'd255, 15, 17, 30};
        vecs[4] = '{8'd1,   1,  3,  0};
        vecs[5] = '{8'd3,   1,  3,  2};
        vecs[6] = '{8'd4,   2,  4,  0};
        vecs[7] = '{8'd99,  9,  11, 18};

        rst_n = 1'b0;
        start = 1'b0;
        operand = 8'd0;
        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_root", int'(root), 0);
        check("reset_opcode", int'(alu_opcode), int'(OP_PASS_AC));
        check("reset_control", int'(alu_control), 0);
        check("reset_ac", int'(alu_ac), 0);
        check("reset_dr", int'(alu_dr), 0);
`ifdef SQRT_REMAINDER_EN
        check("reset_remainder", int'(remainder), 0);
`endif
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].n, 1'b0, r, rem_o, lat, gap, ok);
            check($sformatf("vec%0d_handshake", i), int'(ok), 1);
            check($sformatf("vec%0d_root", i), r, vecs[i].exp_root);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_sub_cycles", i), dr_q.size(), vecs[i].exp_root + 1);
`ifdef SQRT_REMAINDER_EN
            check($sformatf("vec%0d_remainder", i), rem_o, vecs[i].exp_rem);
`endif
            if (vecs[i].n == 8'd255) begin
                for (int j = 0; j < dr_q.size(); j++)
                    check($sformatf("n255_dr%0d", j), dr_q[j], 2 * j + 1);
            end
        end

        // done lasts exactly one cycle
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);

        // Exhaustive back-to-back sweep
        for (int n = 0; n < 256; n++) begin
            run_op(8'(n), 1'b0, r, rem_o, lat, gap, ok);
            check($sformatf("sweep%0d_root", n), r, ref_sqrt(n));
            if (n == 0) check("sweep0_handshake", int'(ok), 1);
            else check($sformatf("sweep%0d_gap", n), gap, 2);
        end

        // start pulsed again while busy with a different operand
        run_op(8'd50, 1'b1, r, rem_o, lat, gap, ok);
        check("poke_handshake", int'(ok), 1);
        check("poke_root", r, 7);
        check("poke_latency", lat, 9);
        @(negedge clk);
        @(negedge clk);
        check("poke_not_queued", int'(busy), 0);

        // Reset during SUB for N=200
        operand = 8'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_pre_busy", int'(busy), 1);
        check("midrst_pre_sub", int'(alu_control), int'(CTL_SUB));
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_root", int'(root), 0);
        check("midrst_opcode", int'(alu_opcode), int'(OP_PASS_AC));
        check("midrst_dr", int'(alu_dr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("midrst_no_activity", pulses, 0);
        run_op(8'd49, 1'b0, r, rem_o, lat, gap, ok);
        check("after_rst_handshake", int'(ok), 1);
        check("after_rst_root", r, 7);
`ifdef SQRT_REMAINDER_EN
        check("after_rst_remainder", rem_o, 0);
`endif

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            int n, er;
            n = $urandom_range(0, 255);
            er = ref_sqrt(n);
            run_op(8'(n), 1'($urandom_range(0, 1)), r, rem_o, lat, gap, ok);
            check($sformatf("rand%0d_n%0d_root", i, n), r, er);
            check($sformatf("rand%0d_n%0d_latency", i, n), lat, er + 2);
`ifdef SQRT_REMAINDER_EN
            check($sformatf("rand%0d_n%0d_remainder", i, n), rem_o, n - er * er);
`endif
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
